// File: rtl/interleaver_pkg.sv
// Shared types for the interleaver frame packer: FSM encoding, default length width
// and the FIFO entry layout {sop, eop, data}.
package interleaver_pkg;

    localparam int unsigned LEN_W_DEF = 12;
    localparam int unsigned FLAG_W    = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Upper bits of every FIFO entry; the data byte follows below them.
    typedef struct packed {
        logic sop;
        logic eop;
    } entry_flags_t;

endpackage

// File: rtl/interleaver_frame_packer_fifo.sv
// packer_fifo: synchronous first-word-fall-through FIFO with full/empty flags.
// Output reads as zero while empty.
module packer_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/interleaver_frame_packer.sv
// Frames an interleaved byte stream into length-delimited blocks (sop/eop) through an FWFT FIFO.
// Optional PACKER_STATS_EN adds frame_count / drop_count outputs.
module interleaver_frame_packer
    import interleaver_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sop,
    output logic              m_eop,
    output logic              overflow,
    output logic              len_err
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count
`endif
);

    localparam int unsigned ENTRY_W = FLAG_W + DATA_W;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                len_err_q, len_err_d;
    logic                overflow_q, overflow_d;
    logic                wr_req_c, wr_sop_c, wr_eop_c;
    logic                push_c, pop_c, drop_c;
    logic                fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]  wr_entry_c, rd_entry;
    entry_flags_t        wr_flags_c, rd_flags;

    // Block framing FSM: count runs 0..len-1 inside a block.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        wr_req_c  = 1'b0;
        wr_sop_c  = 1'b0;
        wr_eop_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    if (length == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        wr_req_c = 1'b1;
                        wr_sop_c = 1'b1;
                        len_d    = length;
                        if (length == LEN_W'(1)) begin
                            wr_eop_c = 1'b1;
                            cnt_d    = '0;
                        end else begin
                            cnt_d   = LEN_W'(1);
                            state_d = ST_ACTIVE;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                if (data_valid) begin
                    wr_req_c = 1'b1;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        wr_eop_c = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign pop_c      = m_valid && m_ready;
    assign push_c     = wr_req_c && (!fifo_full || pop_c);
    assign drop_c     = wr_req_c && fifo_full && !pop_c;
    assign overflow_d = overflow_q || drop_c;

    assign wr_flags_c = '{sop: wr_sop_c, eop: wr_eop_c};
    assign wr_entry_c = {wr_flags_c, data_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            len_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            len_err_q  <= len_err_d;
            overflow_q <= overflow_d;
        end
    end

    packer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_c),
        .wr_data (wr_entry_c),
        .rd_en   (pop_c),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_flags = entry_flags_t'(rd_entry[ENTRY_W-1 -: FLAG_W]);
    assign m_valid  = !fifo_empty;
    assign m_data   = rd_entry[DATA_W-1:0];
    assign m_sop    = rd_flags.sop;
    assign m_eop    = rd_flags.eop;
    assign overflow = overflow_q;
    assign len_err  = len_err_q;

`ifdef PACKER_STATS_EN
    logic [15:0] frame_q, frame_d;
    logic [15:0] drop_q, drop_d;

    // Frames count accepted eop bytes (wrapping); drops saturate.
    always_comb begin
        frame_d = frame_q;
        drop_d  = drop_q;
        if (push_c && wr_eop_c) begin
            frame_d = frame_q + 16'd1;
        end
        if (drop_c && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign frame_count = frame_q;
    assign drop_count  = drop_q;
`endif

endmodule
